// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data stage,
// then sequences the halt: drain outstanding traffic, emit one dump strobe, park.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_done,
    output logic              fetch_stall,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic              data_stall,
    input  logic              halt,
    output logic              halted,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              mem_dump
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DATA,
        S_DUMP,
        S_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              fetch_done_q, fetch_done_d;
    logic              data_done_q, data_done_d;
    logic              mem_dump_q, mem_dump_d;
    logic              halted_q, halted_d;

    // A port whose done pulse is showing has just been served; its held level is not a new request yet.
    logic fetch_act, data_act;
    assign fetch_act = fetch_req & ~fetch_done_q;
    assign data_act  = data_req & ~data_done_q;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state_q;
        starve_d      = starve_q;
        mem_en_d      = mem_en_q;
        mem_wr_d      = mem_wr_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        fetch_rdata_d = fetch_rdata_q;
        data_rdata_d  = data_rdata_q;
        fetch_done_d  = 1'b0;
        data_done_d   = 1'b0;
        mem_dump_d    = 1'b0;
        halted_d      = halted_q;

        case (state_q)
            S_IDLE: begin
                if (halt) begin
                    state_d    = S_DUMP;
                    mem_dump_d = 1'b1;
                end else if (data_act && (!fetch_act || starve_q < LIMIT)) begin
                    state_d     = S_DATA;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = data_wr;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                    if (fetch_req && starve_q != LIMIT) starve_d = starve_q + 1'b1;
                end else if (fetch_act) begin
                    state_d    = S_FETCH;
                    mem_en_d   = 1'b1;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = fetch_addr;
                    starve_d   = '0;
                end
            end
            S_FETCH: begin
                if (mem_done) begin
                    state_d       = S_IDLE;
                    mem_en_d      = 1'b0;
                    fetch_done_d  = 1'b1;
                    fetch_rdata_d = mem_rdata;
                end
            end
            S_DATA: begin
                if (mem_done) begin
                    state_d     = S_IDLE;
                    mem_en_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    data_done_d = 1'b1;
                    if (!mem_wr_q) data_rdata_d = mem_rdata;
                end
            end
            S_DUMP: begin
                state_d  = S_HALTED;
                halted_d = 1'b1;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d  = S_IDLE;
                mem_en_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            starve_q      <= '0;
            mem_en_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
            fetch_done_q  <= 1'b0;
            data_done_q   <= 1'b0;
            mem_dump_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            mem_en_q      <= mem_en_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            fetch_rdata_q <= fetch_rdata_d;
            data_rdata_q  <= data_rdata_d;
            fetch_done_q  <= fetch_done_d;
            data_done_q   <= data_done_d;
            mem_dump_q    <= mem_dump_d;
            halted_q      <= halted_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign fetch_rdata = fetch_rdata_q;
    assign data_rdata  = data_rdata_q;
    assign fetch_done  = fetch_done_q;
    assign data_done   = data_done_q;
    assign mem_dump    = mem_dump_q;
    assign halted      = halted_q;
    assign fetch_stall = fetch_req & ~fetch_done_q;
    assign data_stall  = data_req & ~data_done_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port data/instruction memory between the fetch stage and the memory stage of the pipeline. Grants one requester at a time and holds the granted access on the memory until the memory reports completion. Returns read data and a one-cycle done pulse to the winning requester, and drives stall outputs to the pipeline. Sequences the halt/dump: outstanding traffic drains, then a single dump pulse is issued.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
STARVE_LIMIT, 3, max consecutive data grants while fetch waits before fetch is forced

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
fetch_req  in  1  fetch read request, level, held until fetch_done
fetch_addr  in  ADDR_W  fetch address
fetch_rdata  out  DATA_W  fetch read data, valid with fetch_done, held after
fetch_done  out  1  one-cycle completion pulse
fetch_stall  out  1  fetch_req & ~fetch_done
data_req  in  1  data request, level, held until data_done
data_wr  in  1  1 = write, 0 = read
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  write data
data_rdata  out  DATA_W  data read data, valid with data_done, held after
data_done  out  1  one-cycle completion pulse
data_stall  out  1  data_req & ~data_done
halt  in  1  halt request, level
halted  out  1  high from the cycle after dump until reset
mem_en  out  1  memory enable
mem_wr  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_done
mem_done  in  1  memory completion, may assert in the first mem_en cycle
mem_dump  out  1  one-cycle dump strobe

Behaviour:
- Reset: clk and rst as named; rst is asynchronous, active-high. All outputs 0, state IDLE, starve counter 0, rdata registers 0. Reset mid-access abandons the access, and mem_en drops immediately.
- States: IDLE, FETCH, DATA, DUMP, HALTED.
- IDLE:
  - If halt is high, go to DUMP. Halt has priority over any request.
  - Otherwise, if data_req is high and (fetch_req is low or starve count < STARVE_LIMIT), latch data_addr, data_wdata and data_wr, and go to DATA.
  - Otherwise, if fetch_req is high, latch fetch_addr and go to FETCH.
  - A port whose done is high this cycle is treated as not requesting, so a completed request is never re-granted.
- Starve counter: increments (saturating at STARVE_LIMIT) on each data grant while fetch_req is high. It clears on any fetch grant.
- FETCH and DATA:
  - mem_en is 1, mem_addr and mem_wdata come from latched values, and mem_wr equals latched wr (0 in FETCH).
  - Request inputs are ignored after latching.
  - On mem_done, go to IDLE. On the next cycle, pulse the matching *_done.
  - For a read, load *_rdata from mem_rdata at mem_done. Writes leave data_rdata unchanged.
- Latency: request seen in IDLE at cycle N; mem_en at N+1; done at the cycle after mem_done. With a single-cycle memory, done is at N+2, and the next grant is possible at N+2 (IDLE) with issue at N+3.
- Halt during FETCH or DATA: the access completes normally, then IDLE takes DUMP.
- DUMP: mem_dump=1 for one cycle and mem_en=0, then go to HALTED.
- HALTED: halted=1. No grants, no done pulses, and stalls follow their requests. Exit only by reset.
- mem_en and mem_dump are never high in the same cycle. At most one *_done is high per cycle.

Test Plan:
- Single-cycle memory; fetch_req alone, addr 0x0010, mem_rdata 0xBEEF → mem_en at cycle 1, fetch_done and fetch_rdata=0xBEEF at cycle 2, fetch_stall high cycles 0–1.
- data write addr 0x0020, wdata 0x1234 → mem_wr=1, mem_addr=0x0020, mem_wdata=0x1234 for one cycle; data_done one cycle later; data_rdata unchanged.
- fetch_req and data_req held continuously, STARVE_LIMIT=3 → grant order D,D,D,F,D,D,D,F; no port granted twice for one request.
- mem_done delayed 3 cycles with data read in flight and halt raised → access completes, data_done pulses, then mem_dump is 1 for one cycle, halted=1; later requests keep stall high and mem_en=0.
- rst asserted mid-DATA (mem_en=1) → mem_en, done and mem_dump drop asynchronously; after release, state IDLE, counter 0, rdata=0x0000.
- fetch_req held high across its done cycle → not re-issued in that IDLE cycle; a new request is issued only if still asserted the following IDLE cycle.
